// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths and FSM encoding for the systolic array feeders
// Provides DATA_W_DEF / ADR_W_DEF defaults and the state_t encoding used by vec_feeder.
package systolic_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADR_W_DEF  = 8;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        FINISH = 2'd2
    } state_t;
endpackage

// File: rtl/feed_skid.sv
// feed_skid: two-entry skid buffer between source RAM read data and the FIFO write port
// Ports: clk, rst_n (async active-low), clr (sync flush), push/wdata (capture),
//        pop (drop head), rdata (head word), count (occupancy 0..2).
module feed_skid import systolic_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] e0, e1;
    logic [1:0]        pos;
    // slot the pushed word lands in, after the head has shifted out on a pop
    assign pos   = count - {1'b0, pop};
    assign rdata = e0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else if (clr) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop) e0 <= e1;
            if (push && pos == 2'd0) e0 <= wdata;
            if (push && pos == 2'd1) e1 <= wdata;
        end
    end
endmodule

// File: rtl/vec_feeder.sv
// vec_feeder: streams len words from a source RAM starting at base into a downstream FIFO
// Ports: clk, rst_n (async active-low); start/base/len launch a transfer;
//        ram_ren/ram_radr/ram_rdata read the source RAM (1-cycle read latency);
//        we/din write the FIFO, ff = FIFO full, is = array stall; busy, done status.
// Option: define VEC_FEEDER_SKEW_EN to add the 4-bit skew input, which emits that many
//         zero words ahead of the data words.
module vec_feeder import systolic_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADR_W  = ADR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADR_W-1:0]  base,
    input  logic [ADR_W-1:0]  len,
    output logic              ram_ren,
    output logic [ADR_W-1:0]  ram_radr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              we,
    output logic [DATA_W-1:0] din,
    input  logic              ff,
    input  logic              is,
    output logic              busy,
    output logic              done
`ifdef VEC_FEEDER_SKEW_EN
    ,
    input  logic [3:0]        skew
`endif
);
    state_t            state, state_nx;
    logic [ADR_W-1:0]  base_r, len_r, issued, written;
    logic              inflight, pop, skew_we, sk_busy, last, len_zero;
    logic [1:0]        count;
    logic [DATA_W-1:0] head;
`ifdef VEC_FEEDER_SKEW_EN
    logic [3:0]        skew_left;
    assign sk_busy  = skew_left != 4'd0;
    assign last     = we && (sk_busy ? (skew_left == 4'd1 && len_r == '0) : written + 1'b1 == len_r);
    assign len_zero = len == '0 && skew == 4'd0;
`else
    assign sk_busy  = 1'b0;
    assign last     = pop && written + 1'b1 == len_r;
    assign len_zero = len == '0;
`endif
    assign skew_we  = state == FEED && sk_busy && !is && !ff;
    assign pop      = state == FEED && !sk_busy && count != 2'd0 && !is && !ff;
    assign we       = pop || skew_we;
    assign din      = pop ? head : '0;
    // the head leaving this cycle frees its slot, so a full-rate stream never bubbles
    assign ram_ren  = state == FEED && !is && issued < len_r &&
                      (count - {1'b0, pop} + {1'b0, inflight}) < 2'd2;
    assign ram_radr = base_r + issued;
    assign busy     = state != IDLE;
    assign done     = state == FINISH;
    // start wins over the final write, so a restart swallows the done pulse
    always_comb begin
        state_nx = state;
        if (start) state_nx = len_zero ? FINISH : FEED;
        else if (state == FEED && last) state_nx = FINISH;
        else if (state == FINISH) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_r   <= '0;
            len_r    <= '0;
            issued   <= '0;
            written  <= '0;
            inflight <= 1'b0;
`ifdef VEC_FEEDER_SKEW_EN
            skew_left <= 4'd0;
`endif
        end else begin
            state    <= state_nx;
            // a read issued in the restart cycle belongs to the abandoned transfer
            inflight <= ram_ren && !start;
            if (start) begin
                base_r  <= base;
                len_r   <= len;
                issued  <= '0;
                written <= '0;
`ifdef VEC_FEEDER_SKEW_EN
                skew_left <= skew;
`endif
            end else begin
                if (ram_ren) issued <= issued + 1'b1;
                if (pop) written <= written + 1'b1;
`ifdef VEC_FEEDER_SKEW_EN
                if (skew_we) skew_left <= skew_left - 1'b1;
`endif
            end
        end
    end
    feed_skid #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (inflight),
        .pop   (pop),
        .wdata (ram_rdata),
        .rdata (head),
        .count (count)
    );
endmodule

// File: tb/tb_vec_feeder.sv
// tb_vec_feeder: directed table-driven bench for vec_feeder with a behavioural source RAM
module tb_vec_feeder;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, ff = 1'b0, is_s = 1'b0;
    logic        ram_ren, we, busy, done;
    logic [7:0]  base = 8'h00, len = 8'h00, ram_radr;
    logic [15:0] ram_rdata = 16'h0000, din;
`ifdef VEC_FEEDER_SKEW_EN
    logic [3:0]  skew_v = 4'd0;
`endif
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic [7:0] base;
        logic [7:0] len;
        int ff_lo, ff_hi, is_lo, is_hi, exp_done;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    function automatic logic [15:0] memv(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    always @(posedge clk) if (ram_ren) ram_rdata <= memv(ram_radr);

    vec_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .ram_ren(ram_ren), .ram_radr(ram_radr), .ram_rdata(ram_rdata),
        .we(we), .din(din), .ff(ff), .is(is_s), .busy(busy), .done(done)
`ifdef VEC_FEEDER_SKEW_EN
        , .skew(skew_v)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic [7:0] b, input logic [7:0] l, input logic f, input logic i);
        @(negedge clk);
        start = s; base = b; len = l; ff = f; is_s = i;
        #1;
    endtask

    initial begin
        vec_t v;
        int done_at, ndone, ren_blk, bad;
        logic [15:0] got[$];
        logic [7:0] adr[$];
        int we_k[$];
        logic [7:0] a;
        // base, len, ff window, is window, cycle of done after the start edge
        vecs[0] = '{8'h10, 8'd4, 0, -1, 0, -1, 7};
        vecs[1] = '{8'h80, 8'd6, 4, 9, 0, -1, 15};
        vecs[2] = '{8'hFE, 8'd3, 0, -1, 0, -1, 6};
        vecs[3] = '{8'h00, 8'd0, 0, -1, 0, -1, 1};
        vecs[4] = '{8'h40, 8'd1, 0, -1, 0, -1, 4};
        vecs[5] = '{8'h20, 8'd4, 0, -1, 3, 5, 10};
        vecs[6] = '{8'h70, 8'd2, 3, 3, 0, -1, 6};

        #1 rst_n = 1'b0;
        #2;
        check("rst_we", we, 0);
        check("rst_din", din, 0);
        check("rst_ren", ram_ren, 0);
        check("rst_radr", ram_radr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 7; n++) begin
            v = vecs[n];
            got.delete(); adr.delete();
            done_at = -1; ndone = 0; ren_blk = 0; bad = 0;
            for (int k = 0; k < 24; k++) begin
                tick(k == 0, v.base, v.len, k >= v.ff_lo && k <= v.ff_hi, k >= v.is_lo && k <= v.is_hi);
                if (k > 0) begin
                    if (we) got.push_back(din);
                    if (ram_ren) adr.push_back(ram_radr);
                    if (done) begin ndone++; done_at = k; end
                    if ((ff || is_s) && we) bad++;
                    if (is_s && ram_ren) bad++;
                    if (ff && ram_ren) ren_blk++;
                    if (k == 1 && !busy) bad++;
                end
            end
            check($sformatf("v%0d_n_we", n), got.size(), v.len);
            check($sformatf("v%0d_n_ren", n), adr.size(), v.len);
            for (int i = 0; i < got.size() && i < int'(v.len); i++) begin
                a = v.base + 8'(i);
                check($sformatf("v%0d_word%0d", n, i), got[i], memv(a));
            end
            for (int i = 0; i < adr.size() && i < int'(v.len); i++) begin
                a = v.base + 8'(i);
                check($sformatf("v%0d_radr%0d", n, i), adr[i], a);
            end
            check($sformatf("v%0d_done_cycle", n), done_at, v.exp_done);
            check($sformatf("v%0d_done_count", n), ndone, 1);
            check($sformatf("v%0d_blocked_violations", n), bad, 0);
            check($sformatf("v%0d_ren_blocked_gt2", n), ren_blk > 2, 0);
            check($sformatf("v%0d_idle_busy", n), busy, 0);
        end

        // stall mid-transfer, then reset while stalled
        tick(1, 8'h30, 8'd8, 0, 0);
        tick(0, 8'h30, 8'd8, 0, 0);
        tick(0, 8'h30, 8'd8, 0, 0);
        tick(0, 8'h30, 8'd8, 0, 0);
        check("prestall_we_ren", {we, ram_ren}, 2'b11);
        for (int k = 4; k < 7; k++) begin
            tick(0, 8'h30, 8'd8, 0, 1);
            check($sformatf("stall%0d_we_ren", k), {we, ram_ren}, 2'b00);
            check($sformatf("stall%0d_busy", k), busy, 1);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", we, 0);
        check("midrst_din", din, 0);
        check("midrst_ren", ram_ren, 0);
        check("midrst_radr", ram_radr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ndone = 0; bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick(0, 8'h00, 8'd0, 0, 0);
            if (done) ndone++;
            if (busy || we || ram_ren) bad++;
        end
        check("postrst_done", ndone, 0);
        check("postrst_activity", bad, 0);

        // restart coincident with the final write
        got.delete(); done_at = -1; ndone = 0;
        tick(1, 8'h50, 8'd2, 0, 0);
        for (int k = 1; k < 4; k++) tick(0, 8'h50, 8'd2, 0, 0);
        tick(1, 8'h60, 8'd1, 0, 0);
        check("restart_final_we", we, 1);
        check("restart_final_din", din, memv(8'h51));
        for (int k = 5; k < 13; k++) begin
            tick(0, 8'h60, 8'd1, 0, 0);
            if (we) got.push_back(din);
            if (done) begin ndone++; done_at = k; end
        end
        check("restart_done_cycle", done_at, 8);
        check("restart_done_count", ndone, 1);
        check("restart_n_we", got.size(), 1);
        if (got.size() > 0) check("restart_word", got[0], memv(8'h60));

`ifdef VEC_FEEDER_SKEW_EN
        got.delete(); we_k.delete(); done_at = -1;
        skew_v = 4'd2;
        tick(1, 8'h90, 8'd2, 0, 0);
        skew_v = 4'd0;
        for (int k = 1; k < 10; k++) begin
            tick(0, 8'h90, 8'd2, 0, 0);
            if (we) begin got.push_back(din); we_k.push_back(k); end
            if (done) done_at = k;
        end
        check("skew_n_we", got.size(), 4);
        if (got.size() == 4) begin
            check("skew_w0", got[0], 16'h0000);
            check("skew_w1", got[1], 16'h0000);
            check("skew_w2", got[2], memv(8'h90));
            check("skew_w3", got[3], memv(8'h91));
            check("skew_first_k", we_k[0], 1);
            check("skew_last_k", we_k[3], 4);
        end
        check("skew_done_cycle", done_at, 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
